// File: rtl/interrupt_ack_controller.sv
// rtl/interrupt_ack_controller.sv - IRQ synchronizer, pending latch and IACK responder for a 68k-style bus.
module interrupt_ack_controller #(
   parameter logic [6:0] EDGE_MASK    = 7'b0000000,
   parameter logic [6:0] AUTOVEC_MASK = 7'b1111111,
   parameter logic [7:0] VECTOR_BASE  = 8'h40
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] irq_n,
   input  logic       as_n,
   input  logic       rw,
   input  logic [2:0] fc,
   input  logic [2:0] addr,
   output logic [6:0] req_n,
   output logic       vpa_n,
   output logic       dtack_n,
   output logic       berr_n,
   output logic       vec_oe,
   output logic [7:0] vec_data
);

   typedef enum logic [1:0] {IDLE, ACK, HOLD} state_t;

   state_t     state_q, state_d;
   logic [6:0] irq_s1_q, irq_s1_d;
   logic [6:0] irq_s_q, irq_s_d;
   logic [6:0] irq_prev_q, irq_prev_d;
   logic       as_s1_q, as_s1_d;
   logic       as_s_q, as_s_d;
   logic [6:0] pending_q, pending_d;
   logic       vpa_n_q, vpa_n_d;
   logic       dtack_n_q, dtack_n_d;
   logic       berr_n_q, berr_n_d;
   logic       vec_oe_q, vec_oe_d;
   logic [7:0] vec_data_q, vec_data_d;

   logic [6:0] fall;
   logic [7:0] pend_ext;
   logic [7:0] auto_ext;
   logic [7:0] lvl_sel;
   logic       lvl_valid;

   always_comb begin
      irq_s1_d   = irq_n;
      irq_s_d    = irq_s1_q;
      irq_prev_d = irq_s_q;
      as_s1_d    = as_n;
      as_s_d     = as_s1_q;

      fall      = irq_prev_q & ~irq_s_q;
      pending_d = (EDGE_MASK & (pending_q | fall)) | (~EDGE_MASK & ~irq_s_q);

      // Bit 0 of the extended vectors stands for level 0, which is never valid.
      pend_ext  = {pending_q, 1'b0};
      auto_ext  = {AUTOVEC_MASK, 1'b0};
      lvl_sel   = 8'd1 << addr;
      lvl_valid = pend_ext[addr];

      state_d    = state_q;
      vpa_n_d    = vpa_n_q;
      dtack_n_d  = dtack_n_q;
      berr_n_d   = berr_n_q;
      vec_oe_d   = vec_oe_q;
      vec_data_d = vec_data_q;

      case (state_q)
         IDLE: begin
            if (!as_s_q) begin
               state_d = (fc == 3'b111 && rw) ? ACK : HOLD;
            end
         end
         ACK: begin
            state_d = HOLD;
            if (lvl_valid) begin
               if (auto_ext[addr]) begin
                  vpa_n_d = 1'b0;
               end else begin
                  dtack_n_d  = 1'b0;
                  vec_oe_d   = 1'b1;
                  vec_data_d = VECTOR_BASE + {5'b00000, addr};
               end
               // A fresh edge arriving during the acknowledge keeps the request alive.
               pending_d = pending_d & ~(lvl_sel[7:1] & EDGE_MASK & ~fall);
            end else begin
               berr_n_d = 1'b0;
            end
         end
         HOLD: begin
            if (as_s_q) begin
               state_d    = IDLE;
               vpa_n_d    = 1'b1;
               dtack_n_d  = 1'b1;
               berr_n_d   = 1'b1;
               vec_oe_d   = 1'b0;
               vec_data_d = 8'h00;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         irq_s1_q   <= 7'h7F;
         irq_s_q    <= 7'h7F;
         irq_prev_q <= 7'h7F;
         as_s1_q    <= 1'b1;
         as_s_q     <= 1'b1;
         pending_q  <= 7'h00;
         vpa_n_q    <= 1'b1;
         dtack_n_q  <= 1'b1;
         berr_n_q   <= 1'b1;
         vec_oe_q   <= 1'b0;
         vec_data_q <= 8'h00;
      end else begin
         state_q    <= state_d;
         irq_s1_q   <= irq_s1_d;
         irq_s_q    <= irq_s_d;
         irq_prev_q <= irq_prev_d;
         as_s1_q    <= as_s1_d;
         as_s_q     <= as_s_d;
         pending_q  <= pending_d;
         vpa_n_q    <= vpa_n_d;
         dtack_n_q  <= dtack_n_d;
         berr_n_q   <= berr_n_d;
         vec_oe_q   <= vec_oe_d;
         vec_data_q <= vec_data_d;
      end
   end

   assign req_n    = ~pending_q;
   assign vpa_n    = vpa_n_q;
   assign dtack_n  = dtack_n_q;
   assign berr_n   = berr_n_q;
   assign vec_oe   = vec_oe_q;
   assign vec_data = vec_data_q;

endmodule

// File: tb/tb_interrupt_ack_controller.sv
// tb/tb_interrupt_ack_controller.sv - directed plus random check of interrupt_ack_controller against a transaction-level model.
module tb_interrupt_ack_controller;

   localparam logic [6:0] EM = 7'b1000000;
   localparam logic [6:0] AM = 7'b1111101;
   localparam logic [7:0] VB = 8'h40;

   logic       clk = 1'b0;
   logic       reset;
   logic [6:0] irq_n;
   logic       as_n;
   logic       rw;
   logic [2:0] fc;
   logic [2:0] addr;
   logic [6:0] req_n;
   logic       vpa_n;
   logic       dtack_n;
   logic       berr_n;
   logic       vec_oe;
   logic [7:0] vec_data;

   int total = 0;
   int bad   = 0;

   logic [6:0] m_pend;
   logic [6:0] m_irq;

   interrupt_ack_controller #(
      .EDGE_MASK    (EM),
      .AUTOVEC_MASK (AM),
      .VECTOR_BASE  (VB)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .irq_n    (irq_n),
      .as_n     (as_n),
      .rw       (rw),
      .fc       (fc),
      .addr     (addr),
      .req_n    (req_n),
      .vpa_n    (vpa_n),
      .dtack_n  (dtack_n),
      .berr_n   (berr_n),
      .vec_oe   (vec_oe),
      .vec_data (vec_data)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_resp(input string tag, input logic ev, input logic ed, input logic eb,
                           input logic eo, input logic [7:0] evec);
      chk({tag, "_vpa"},   {31'd0, vpa_n},   {31'd0, ev});
      chk({tag, "_dtack"}, {31'd0, dtack_n}, {31'd0, ed});
      chk({tag, "_berr"},  {31'd0, berr_n},  {31'd0, eb});
      chk({tag, "_oe"},    {31'd0, vec_oe},  {31'd0, eo});
      chk({tag, "_vec"},   {24'd0, vec_data}, {24'd0, evec});
   endtask

   // Level lines follow the input; edge lines latch on a high-to-low step.
   task automatic set_irq(input logic [6:0] v);
      for (int i = 0; i < 7; i++) begin
         if (EM[i]) begin
            if (m_irq[i] && !v[i]) m_pend[i] = 1'b1;
         end else begin
            m_pend[i] = ~v[i];
         end
      end
      m_irq = v;
      irq_n = v;
      repeat (4) tick();
      chk("req_n", {25'd0, req_n}, {25'd0, ~m_pend});
   endtask

   task automatic iack(input logic [2:0] a, input logic [2:0] f, input logic r, input bit re_edge);
      logic       ev, ed, eb, eo;
      logic [7:0] evec;
      int         li;
      ev = 1'b1; ed = 1'b1; eb = 1'b1; eo = 1'b0; evec = 8'h00;
      li = int'(a) - 1;
      if (f == 3'b111 && r) begin
         if (a != 3'd0 && m_pend[li]) begin
            if (AM[li]) ev = 1'b0;
            else begin
               ed = 1'b0; eo = 1'b1; evec = VB + {5'd0, a};
            end
            if (EM[li] && !re_edge) m_pend[li] = 1'b0;
         end else begin
            eb = 1'b0;
         end
      end
      fc = f; rw = r; addr = a; as_n = 1'b0;
      tick();
      if (re_edge) begin
         irq_n[6] = 1'b0;
         m_irq[6] = 1'b0;
      end
      tick();
      tick();
      chk_resp("iack_pre", 1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
      tick();
      chk_resp("iack_resp", ev, ed, eb, eo, evec);
      tick();
      chk_resp("iack_hold", ev, ed, eb, eo, evec);
      as_n = 1'b1;
      tick();
      tick();
      chk_resp("iack_tail", ev, ed, eb, eo, evec);
      tick();
      chk_resp("iack_done", 1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
      tick();
      chk("iack_req_n", {25'd0, req_n}, {25'd0, ~m_pend});
   endtask

   initial begin
      reset = 1'b1; irq_n = 7'h7F; as_n = 1'b1; rw = 1'b1; fc = 3'b000; addr = 3'd0;
      m_pend = 7'h00; m_irq = 7'h7F;
      tick();
      tick();
      chk_resp("reset", 1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
      chk("reset_req_n", {25'd0, req_n}, 32'h7F);
      reset = 1'b0;
      tick();

      // Level 3 latency: request visible exactly three edges after the input moves.
      irq_n = 7'b1111011; m_irq = irq_n; m_pend = 7'b0000100;
      tick();
      tick();
      chk("lvl3_early", {25'd0, req_n}, 32'h7F);
      tick();
      chk("lvl3_set", {25'd0, req_n}, {25'd0, 7'b1111011});
      irq_n = 7'h7F; m_irq = irq_n; m_pend = 7'h00;
      tick();
      tick();
      chk("lvl3_hold", {25'd0, req_n}, {25'd0, 7'b1111011});
      tick();
      chk("lvl3_rel", {25'd0, req_n}, 32'h7F);

      // Autovector at level 5, vectored at level 2, level stays pending.
      set_irq(7'b1101111);
      iack(3'd5, 3'b111, 1'b1, 1'b0);
      set_irq(7'b1111101);
      iack(3'd2, 3'b111, 1'b1, 1'b0);
      set_irq(7'h7F);

      // Spurious acknowledges.
      iack(3'd4, 3'b111, 1'b1, 1'b0);
      iack(3'd0, 3'b111, 1'b1, 1'b0);

      // Edge level 7: latch, clear by IACK, then re-edge during ACK keeps it.
      set_irq(7'b0111111);
      set_irq(7'h7F);
      chk("edge7_latched", {31'd0, req_n[6]}, 32'd0);
      iack(3'd7, 3'b111, 1'b1, 1'b0);
      chk("edge7_cleared", {31'd0, req_n[6]}, 32'd1);
      set_irq(7'b0111111);
      set_irq(7'h7F);
      iack(3'd7, 3'b111, 1'b1, 1'b1);
      chk("edge7_reedge", {31'd0, req_n[6]}, 32'd0);
      set_irq(7'h7F);

      for (int n = 0; n < 30; n++) begin
         set_irq(7'($urandom));
         if ($urandom_range(0, 1) == 1) begin
            iack(3'($urandom), ($urandom_range(0, 9) < 7) ? 3'b111 : 3'($urandom),
                 1'($urandom_range(0, 4) != 0), 1'b0);
         end
      end

      // Non-IACK read gives no response.
      set_irq(7'b1101111);
      iack(3'd5, 3'b101, 1'b1, 1'b0);

      // Reset in the middle of an acknowledge.
      fc = 3'b111; rw = 1'b1; addr = 3'd5; as_n = 1'b0;
      repeat (4) tick();
      chk_resp("pre_reset", ~m_pend[4] ? 1'b1 : 1'b0, 1'b1, m_pend[4] ? 1'b1 : 1'b0, 1'b0, 8'h00);
      reset = 1'b1; irq_n = 7'h7F;
      tick();
      chk_resp("mid_reset", 1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
      chk("mid_reset_req_n", {25'd0, req_n}, 32'h7F);
      m_pend = 7'h00; m_irq = 7'h7F;
      reset = 1'b0;
      repeat (3) tick();
      chk_resp("post_reset_pre", 1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
      tick();
      chk_resp("post_reset_resp", 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
      as_n = 1'b1;
      repeat (3) tick();
      chk_resp("post_reset_done", 1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
      chk("post_reset_req_n", {25'd0, req_n}, 32'h7F);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
